// File: rtl/regfile_mp.sv
// Multi-read-port register file with a per-register pending (scoreboard) bit.
// Register 0 is hardwired to zero and can never be marked pending. Reads are
// combinational with write-through bypass; the long-latency port (we1) wins
// over the pipeline port (we0) on any address collision.
module regfile_mp #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                set_en,
  input  logic [AW-1:0]       set_addr,
  output logic                busy_any
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;

  // Writes and sets aimed at register 0 are dropped here, once, for all users.
  logic w_wr0;
  logic w_wr1;
  logic w_set;

  assign w_wr0 = we0 && (waddr0 != '0);
  assign w_wr1 = we1 && (waddr1 != '0);
  assign w_set = set_en && (set_addr != '0);

  // Data storage: we1 is applied last so it wins a same-address collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_wr0) r_regs[waddr0] <= wdata0;
      if (w_wr1) r_regs[waddr1] <= wdata1;
    end
  end

  // Scoreboard: we1 retires, set marks pending; set applied last so it wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (w_wr1) r_busy[waddr1] <= 1'b0;
      if (w_set) r_busy[set_addr] <= 1'b1;
    end
  end

  // No same-cycle bypass: reflects stored pending state only.
  assign busy_any = |r_busy;

  // Independent read ports with write-through bypass.
  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_hit0;
    logic          w_hit1;

    assign w_ra   = raddr[k*AW +: AW];
    assign w_hit1 = w_wr1 && (waddr1 == w_ra);
    assign w_hit0 = w_wr0 && (waddr0 == w_ra);

    assign rdata[k*XLEN +: XLEN] = (w_ra == '0) ? '0     :
                                   w_hit1       ? wdata1 :
                                   w_hit0       ? wdata0 :
                                                  r_regs[w_ra];

    // A retiring write this cycle hides the pending bit; a same-cycle set does not show yet.
    assign rbusy[k] = (w_ra != '0) && !w_hit1 && r_busy[w_ra];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expectations are queued as stimulus is
// applied and popped in order when the DUT outputs are sampled.
module tb_regfile_mp;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned AW   = 5;

  logic                clock = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                we0;
  logic [AW-1:0]       waddr0;
  logic [XLEN-1:0]     wdata0;
  logic                we1;
  logic [AW-1:0]       waddr1;
  logic [XLEN-1:0]     wdata1;
  logic                set_en;
  logic [AW-1:0]       set_addr;
  logic                busy_any;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clock    (clock),
    .reset    (reset),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .we0      (we0),
    .waddr0   (waddr0),
    .wdata0   (wdata0),
    .we1      (we1),
    .waddr1   (waddr1),
    .wdata1   (wdata1),
    .set_en   (set_en),
    .set_addr (set_addr),
    .busy_any (busy_any)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t x;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h expected <queued entry>", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
      end
    end
  endtask

  // Advance one edge and move 1 ns past it before touching inputs.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    set_en = 1'b0; set_addr = '0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  function automatic logic [31:0] pat(input logic [AW-1:0] a);
    return 32'hA000_0000 | ({27'd0, a} << 8) | {27'd0, a} | 32'h0050_0000;
  endfunction

  initial begin
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    idle();
    reset = 1'b1;
    raddr = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state on every address and both ports.
    for (int i = 0; i < int'(NREG); i++) begin
      a0 = AW'(i);
      a1 = AW'(NREG - 1 - i);
      set_ra(a0, a1);
      push("rst_rdata0", 32'd0);
      push("rst_rdata1", 32'd0);
      push("rst_rbusy", 32'd0);
      push("rst_busy_any", 32'd0);
      #1;
      chk(rdata[31:0]);
      chk(rdata[63:32]);
      chk({30'd0, rbusy});
      chk({31'd0, busy_any});
    end

    // Fill registers through we0, then read back with differing port addresses.
    for (int i = 1; i < int'(NREG); i++) begin
      a0 = AW'(i);
      we0 = 1'b1; waddr0 = a0; wdata0 = pat(a0);
      tick();
    end
    idle();
    for (int i = 0; i < int'(NREG); i++) begin
      a0 = AW'(i);
      a1 = AW'(i * 7 + 3);
      set_ra(a0, a1);
      push("fill_rd0", (a0 == 0) ? 32'd0 : pat(a0));
      push("fill_rd1", (a1 == 0) ? 32'd0 : pat(a1));
      #1;
      chk(rdata[31:0]);
      chk(rdata[63:32]);
    end

    // Same-address double write: we1 wins, bypass and storage.
    set_ra(5, 5);
    we0 = 1'b1; waddr0 = 5; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5; wdata1 = 32'h22;
    push("dual_wr_bypass0", 32'h22);
    push("dual_wr_bypass1", 32'h22);
    #1;
    chk(rdata[31:0]);
    chk(rdata[63:32]);
    tick();
    idle();
    push("dual_wr_stored", 32'h22);
    #1;
    chk(rdata[31:0]);

    // we0-only bypass on port 1.
    set_ra(5, 6);
    we0 = 1'b1; waddr0 = 6; wdata0 = 32'h66;
    push("we0_bypass", 32'h66);
    #1;
    chk(rdata[63:32]);
    tick();
    idle();
    push("we0_stored", 32'h66);
    #1;
    chk(rdata[63:32]);

    // Register 0 is immune to writes and sets.
    set_ra(0, 0);
    we0 = 1'b1; waddr0 = 0; wdata0 = 32'hDEADBEEF;
    set_en = 1'b1; set_addr = 0;
    push("r0_bypass", 32'd0);
    push("r0_rbusy_now", 32'd0);
    #1;
    chk(rdata[31:0]);
    chk({30'd0, rbusy});
    tick();
    idle();
    push("r0_stored", 32'd0);
    push("r0_rbusy", 32'd0);
    push("r0_busy_any", 32'd0);
    #1;
    chk(rdata[31:0]);
    chk({30'd0, rbusy});
    chk({31'd0, busy_any});

    // Scoreboard set then retire on register 7.
    set_ra(7, 7);
    set_en = 1'b1; set_addr = 7;
    push("r7_set_rbusy_now", 32'd0);
    push("r7_set_any_now", 32'd0);
    #1;
    chk({30'd0, rbusy});
    chk({31'd0, busy_any});
    tick();
    idle();
    push("r7_rbusy", 32'd3);
    push("r7_busy_any", 32'd1);
    #1;
    chk({30'd0, rbusy});
    chk({31'd0, busy_any});
    we1 = 1'b1; waddr1 = 7; wdata1 = 32'hA5;
    push("r7_clr_rbusy_now", 32'd0);
    push("r7_clr_rdata_now", 32'hA5);
    push("r7_clr_any_now", 32'd1);
    #1;
    chk({30'd0, rbusy});
    chk(rdata[31:0]);
    chk({31'd0, busy_any});
    tick();
    idle();
    push("r7_clr_any", 32'd0);
    push("r7_clr_rdata", 32'hA5);
    #1;
    chk({31'd0, busy_any});
    chk(rdata[31:0]);

    // Simultaneous set and retire on register 9: bit ends set, data written.
    set_ra(9, 9);
    set_en = 1'b1; set_addr = 9;
    we1 = 1'b1; waddr1 = 9; wdata1 = 32'h99;
    tick();
    idle();
    push("r9_rbusy", 32'd3);
    push("r9_rdata", 32'h99);
    push("r9_busy_any", 32'd1);
    #1;
    chk({30'd0, rbusy});
    chk(rdata[31:0]);
    chk({31'd0, busy_any});

    // we0 neither hides nor clears a pending bit.
    we0 = 1'b1; waddr0 = 9; wdata0 = 32'h77;
    push("r9_we0_rbusy_now", 32'd3);
    push("r9_we0_rdata_now", 32'h77);
    #1;
    chk({30'd0, rbusy});
    chk(rdata[31:0]);
    tick();
    idle();
    push("r9_we0_rbusy", 32'd3);
    #1;
    chk({30'd0, rbusy});
    we1 = 1'b1; waddr1 = 9; wdata1 = 32'h9A;
    tick();
    idle();
    push("r9_retired_any", 32'd0);
    #1;
    chk({31'd0, busy_any});

    // Reset while 3 and 4 are pending; writes/sets during reset are dropped.
    set_en = 1'b1; set_addr = 3;
    tick();
    set_addr = 4;
    tick();
    idle();
    set_ra(3, 4);
    push("pend_rbusy", 32'd3);
    push("pend_any", 32'd1);
    #1;
    chk({30'd0, rbusy});
    chk({31'd0, busy_any});
    reset = 1'b1;
    we0 = 1'b1; waddr0 = 3; wdata0 = 32'h33;
    set_en = 1'b1; set_addr = 5;
    push("rst_bypass", 32'h33);
    #1;
    chk(rdata[31:0]);
    tick();
    reset = 1'b0;
    idle();
    push("post_rst_any", 32'd0);
    push("post_rst_r3", 32'd0);
    push("post_rst_r4", 32'd0);
    push("post_rst_rbusy", 32'd0);
    #1;
    chk({31'd0, busy_any});
    chk(rdata[31:0]);
    chk(rdata[63:32]);
    chk({30'd0, rbusy});
    set_ra(5, 6);
    push("post_rst_r5", 32'd0);
    push("post_rst_r6", 32'd0);
    #1;
    chk(rdata[31:0]);
    chk(rdata[63:32]);

    // Retire to a formerly pending register is a plain write now.
    set_ra(3, 3);
    we1 = 1'b1; waddr1 = 3; wdata1 = 32'h3;
    push("late_we1_rdata_now", 32'h3);
    push("late_we1_rbusy_now", 32'd0);
    #1;
    chk(rdata[31:0]);
    chk({30'd0, rbusy});
    tick();
    idle();
    push("late_we1_rdata", 32'h3);
    push("late_we1_any", 32'd0);
    push("late_we1_rbusy", 32'd0);
    #1;
    chk(rdata[31:0]);
    chk({31'd0, busy_any});
    chk({30'd0, rbusy});

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
